// File: rtl/diffusion_rmw_ctrl_if.sv
// diffusion_rmw_ctrl_if: update handshake, clear control and BRAM port bundle for the diffusion RMW front end
interface diffusion_rmw_ctrl_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                  i_clear_start;
  logic                  o_clear_busy;
  logic                  i_upd_valid;
  logic                  o_upd_ready;
  logic [ADDR_WIDTH-1:0] i_upd_addr;
  logic [DATA_WIDTH-1:0] i_upd_delta;
  logic                  o_upd_done;
  logic                  o_sat;
  logic [ADDR_WIDTH-1:0] o_bram_addr;
  logic                  o_bram_write;
  logic [DATA_WIDTH-1:0] o_bram_data;
  logic [DATA_WIDTH-1:0] i_bram_data;
  modport slave (
    input  i_clear_start, i_upd_valid, i_upd_addr, i_upd_delta, i_bram_data,
    output o_clear_busy, o_upd_ready, o_upd_done, o_sat, o_bram_addr, o_bram_write, o_bram_data
  );
  modport master (
    output i_clear_start, i_upd_valid, i_upd_addr, i_upd_delta, i_bram_data,
    input  o_clear_busy, o_upd_ready, o_upd_done, o_sat, o_bram_addr, o_bram_write, o_bram_data
  );
endinterface

// File: rtl/diffusion_rmw_ctrl.sv
// diffusion_rmw_ctrl: saturating read-modify-write and clear sweep in front of a single-port BRAM
module diffusion_rmw_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8192
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  diffusion_rmw_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RD, ADD, WR, CLR} state_t;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] delta_q, delta_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sat_q, sat_d;
  logic [DATA_WIDTH:0]   sum;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] clamp;
  // one extra bit of headroom: overflow shows up as disagreement of the top two bits
  assign sum   = {bus.i_bram_data[DATA_WIDTH-1], bus.i_bram_data} + {delta_q[DATA_WIDTH-1], delta_q};
  assign ovf   = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
  assign clamp = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  assign bus.o_upd_ready  = (state_q == IDLE) && !bus.i_clear_start;
  assign bus.o_bram_addr  = addr_q;
  assign bus.o_bram_data  = data_q;
  assign bus.o_bram_write = write_q;
  assign bus.o_clear_busy = busy_q;
  assign bus.o_upd_done   = done_q;
  assign bus.o_sat        = sat_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    delta_d = delta_q;
    cnt_d   = cnt_q;
    write_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sat_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_clear_start) begin
          state_d = CLR;
          cnt_d   = '0;
          addr_d  = '0;
          data_d  = '0;
          write_d = 1'b1;
          busy_d  = 1'b1;
        end else if (bus.i_upd_valid) begin
          state_d = RD;
          addr_d  = bus.i_upd_addr;
          delta_d = bus.i_upd_delta;
        end
      end
      RD: state_d = ADD;
      ADD: begin
        state_d = WR;
        data_d  = ovf ? clamp : sum[DATA_WIDTH-1:0];
        write_d = 1'b1;
        done_d  = 1'b1;
        sat_d   = ovf;
      end
      WR: state_d = IDLE;
      CLR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          addr_d  = cnt_d[ADDR_WIDTH-1:0];
          write_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      delta_q <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      delta_q <= delta_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end
endmodule

// File: tb/tb_diffusion_rmw_ctrl.sv
// tb_diffusion_rmw_ctrl: directed checks of update, saturation, clear sweep and reset behaviour
module tb_diffusion_rmw_ctrl;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int DEPTH = 8192;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writes42 = 0;
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic [DW-1:0] last_data;
  logic last_sat;
  diffusion_rmw_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  diffusion_rmw_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.o_bram_write && bus.o_bram_addr == AW'(42)) writes42 <= writes42 + 1;
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i + 1);
    else if (bus.o_bram_write) mem[bus.o_bram_addr] <= bus.o_bram_data;
    else bus.i_bram_data <= mem[bus.o_bram_addr];
  end
  function automatic logic [DW:0] sat_add(logic [DW-1:0] a, logic [DW-1:0] d);
    longint s;
    s = longint'($signed(a)) + longint'($signed(d));
    if (s > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_update(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
    logic [DW:0] r;
    int t0;
    r = sat_add(model_mem[a], d);
    bus.i_upd_valid = 1'b1;
    bus.i_upd_addr  = a;
    bus.i_upd_delta = d;
    #1;
    checks++;
    if (bus.o_upd_ready !== 1'b1) begin errors++; $display("FAIL %s ready_idle got %b want 1", name, bus.o_upd_ready); end
    t0 = cyc;
    step();
    bus.i_upd_valid = 1'b0;
    bus.i_upd_addr  = ~a;
    bus.i_upd_delta = ~d;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.o_upd_ready !== 1'b0 || bus.o_upd_done !== 1'b0) begin
        errors++; $display("FAIL %s busy_cycle%0d ready=%b done=%b want 0 0", name, k, bus.o_upd_ready, bus.o_upd_done);
      end
      step();
    end
    checks++;
    if (bus.o_upd_done !== 1'b1 || bus.o_bram_write !== 1'b1 || bus.o_bram_addr !== a ||
        bus.o_bram_data !== r[DW-1:0] || bus.o_sat !== r[DW] || bus.o_upd_ready !== 1'b0 || cyc - t0 != 3) begin
      errors++;
      $display("FAIL %s writeback done=%b wr=%b addr=%0d data=%h sat=%b lat=%0d want 1 1 %0d %h %b 3",
               name, bus.o_upd_done, bus.o_bram_write, bus.o_bram_addr, bus.o_bram_data, bus.o_sat, cyc - t0, a, r[DW-1:0], r[DW]);
    end
    last_data = bus.o_bram_data;
    last_sat  = bus.o_sat;
    step();
    checks++;
    if (bus.o_upd_done !== 1'b0 || bus.o_bram_write !== 1'b0 || bus.o_sat !== 1'b0 || mem[a] !== r[DW-1:0]) begin
      errors++;
      $display("FAIL %s after done=%b wr=%b sat=%b mem=%h want 0 0 0 %h", name, bus.o_upd_done, bus.o_bram_write, bus.o_sat, mem[a], r[DW-1:0]);
    end
    model_mem[a] = r[DW-1:0];
  endtask
  task automatic run_sweep(input string name);
    int n = 0;
    int bad = 0;
    int nz = 0;
    bus.i_clear_start = 1'b1;
    #1;
    checks++;
    if (bus.o_upd_ready !== 1'b0) begin errors++; $display("FAIL %s ready_on_start got %b want 0", name, bus.o_upd_ready); end
    step();
    bus.i_clear_start = 1'b0;
    while (bus.o_clear_busy === 1'b1 && n < DEPTH + 4) begin
      if (bus.o_bram_write !== 1'b1 || bus.o_bram_addr !== AW'(n) || bus.o_bram_data !== '0 ||
          bus.o_upd_ready !== 1'b0 || bus.o_upd_done !== 1'b0) bad++;
      if (n == 17) bus.i_clear_start = 1'b1;
      if (n == 18) bus.i_clear_start = 1'b0;
      n++;
      step();
    end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, n, DEPTH); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s sweep_cycles bad=%0d want 0", name, bad); end
    checks++;
    if (bus.o_bram_write !== 1'b0) begin errors++; $display("FAIL %s write_after got %b want 0", name, bus.o_bram_write); end
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
    checks++;
    if (nz != 0) begin errors++; $display("FAIL %s nonzero_words got %0d want 0", name, nz); end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask
  task automatic test_reset();
    bus.i_clear_start = 1'b0;
    bus.i_upd_valid   = 1'b0;
    bus.i_upd_addr    = '0;
    bus.i_upd_delta   = '0;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.o_bram_addr !== '0 || bus.o_bram_write !== 1'b0 || bus.o_bram_data !== '0 ||
        bus.o_clear_busy !== 1'b0 || bus.o_upd_done !== 1'b0 || bus.o_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs addr=%0d wr=%b data=%h busy=%b done=%b sat=%b want all 0",
               bus.o_bram_addr, bus.o_bram_write, bus.o_bram_data, bus.o_clear_busy, bus.o_upd_done, bus.o_sat);
    end
    preload = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (bus.o_upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.o_upd_ready); end
  endtask
  task automatic test_clear();
    run_sweep("clear");
    do_update(AW'(100), '0, "read100");
    checks++;
    if (last_data !== '0) begin errors++; $display("FAIL read100 got %h want 0", last_data); end
  endtask
  task automatic test_updates();
    do_update(AW'(5), 32'd10, "upd5_plus10");
    do_update(AW'(5), -32'sd3, "upd5_minus3");
    checks++;
    if (mem[5] !== 32'd7 || last_data !== 32'd7) begin errors++; $display("FAIL upd5_result mem=%h wb=%h want 7", mem[5], last_data); end
  endtask
  task automatic test_saturation();
    do_update(AW'(9), 32'h7FFF_FFF0, "sat_pre_max");
    do_update(AW'(9), 32'h0000_0020, "sat_max");
    checks++;
    if (mem[9] !== 32'h7FFF_FFFF || last_sat !== 1'b1) begin errors++; $display("FAIL sat_max mem=%h sat=%b want 7fffffff 1", mem[9], last_sat); end
    do_update(AW'(10), 32'h8000_0005, "sat_pre_min");
    checks++;
    if (last_sat !== 1'b0) begin errors++; $display("FAIL sat_pre_min sat=%b want 0", last_sat); end
    do_update(AW'(10), 32'hFFFF_FFF0, "sat_min");
    checks++;
    if (mem[10] !== 32'h8000_0000 || last_sat !== 1'b1) begin errors++; $display("FAIL sat_min mem=%h sat=%b want 80000000 1", mem[10], last_sat); end
  endtask
  task automatic test_clear_priority();
    bus.i_upd_valid = 1'b1;
    bus.i_upd_addr  = AW'(77);
    bus.i_upd_delta = 32'd5;
    run_sweep("clear_prio");
    do_update(AW'(77), 32'd5, "after_prio");
    checks++;
    if (mem[77] !== 32'd5) begin errors++; $display("FAIL after_prio mem=%h want 5", mem[77]); end
  endtask
  task automatic test_reset_mid_add();
    int w0;
    do_update(AW'(3), 32'h1234_5678, "pre_rst");
    w0 = writes42;
    bus.i_upd_valid = 1'b1;
    bus.i_upd_addr  = AW'(42);
    bus.i_upd_delta = 32'd9;
    step();
    bus.i_upd_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_bram_addr !== '0 || bus.o_bram_write !== 1'b0 || bus.o_bram_data !== '0 ||
        bus.o_clear_busy !== 1'b0 || bus.o_upd_done !== 1'b0 || bus.o_sat !== 1'b0) begin
      errors++;
      $display("FAIL rst_add_outputs addr=%0d wr=%b data=%h busy=%b done=%b sat=%b want all 0",
               bus.o_bram_addr, bus.o_bram_write, bus.o_bram_data, bus.o_clear_busy, bus.o_upd_done, bus.o_sat);
    end
    step();
    rst = 1'b0;
    repeat (4) step();
    checks++;
    if (writes42 != w0 || mem[42] !== '0) begin errors++; $display("FAIL rst_add_nowrite writes=%0d mem=%h want %0d 0", writes42, mem[42], w0); end
  endtask
  task automatic test_reset_mid_clear();
    int n = 0;
    bus.i_clear_start = 1'b1;
    step();
    bus.i_clear_start = 1'b0;
    while (bus.o_bram_addr !== AW'(300) && n < 400) begin n++; step(); end
    checks++;
    if (bus.o_bram_addr !== AW'(300) || bus.o_clear_busy !== 1'b1) begin
      errors++; $display("FAIL rst_clr_reach addr=%0d busy=%b want 300 1", bus.o_bram_addr, bus.o_clear_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_clear_busy !== 1'b0 || bus.o_bram_write !== 1'b0 || bus.o_bram_addr !== '0) begin
      errors++; $display("FAIL rst_clr_outputs busy=%b wr=%b addr=%0d want 0 0 0", bus.o_clear_busy, bus.o_bram_write, bus.o_bram_addr);
    end
    step();
    rst = 1'b0;
    step();
    run_sweep("clear_restart");
  endtask
  task automatic test_back_to_back();
    logic [AW-1:0] va [4] = '{AW'(17), AW'(4000), AW'(17), AW'(8191)};
    logic [DW-1:0] vd [4] = '{32'h7FFF_FFF0, 32'hFFFF_FFFB, 32'h0000_0100, 32'h8000_0000};
    logic [DW:0] r;
    int th [4];
    bus.i_upd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.i_upd_addr  = va[k];
      bus.i_upd_delta = vd[k];
      #1;
      checks++;
      if (bus.o_upd_ready !== 1'b1) begin errors++; $display("FAIL burst%0d ready got %b want 1", k, bus.o_upd_ready); end
      r = sat_add(model_mem[va[k]], vd[k]);
      model_mem[va[k]] = r[DW-1:0];
      th[k] = cyc;
      step();
      checks++;
      if (bus.o_upd_ready !== 1'b0) begin errors++; $display("FAIL burst%0d ready_rd got %b want 0", k, bus.o_upd_ready); end
      step();
      step();
      checks++;
      if (bus.o_upd_done !== 1'b1 || bus.o_bram_addr !== va[k] || bus.o_bram_data !== r[DW-1:0] || bus.o_sat !== r[DW]) begin
        errors++;
        $display("FAIL burst%0d wb done=%b addr=%0d data=%h sat=%b want 1 %0d %h %b",
                 k, bus.o_upd_done, bus.o_bram_addr, bus.o_bram_data, bus.o_sat, va[k], r[DW-1:0], r[DW]);
      end
      step();
      if (k > 0) begin
        checks++;
        if (th[k] - th[k-1] != 4) begin errors++; $display("FAIL burst%0d spacing got %0d want 4", k, th[k] - th[k-1]); end
      end
    end
    bus.i_upd_valid = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[va[k]] !== model_mem[va[k]]) begin errors++; $display("FAIL burst_mem addr=%0d got %h want %h", va[k], mem[va[k]], model_mem[va[k]]); end
    end
    checks++;
    if (mem[17] !== 32'h7FFF_FFFF || mem[4000] !== 32'hFFFF_FFFB || mem[8191] !== 32'h8000_0000) begin
      errors++; $display("FAIL burst_const m17=%h m4000=%h m8191=%h want 7fffffff fffffffb 80000000", mem[17], mem[4000], mem[8191]);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_clear();
    test_updates();
    test_saturation();
    test_clear_priority();
    test_reset_mid_add();
    test_reset_mid_clear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/diffusion_rmw_ctrl.md
Name: diffusion_rmw_ctrl

Overview:
- Read-modify-write front end sitting directly upstream of the diffusion-stage BRAM (single port, 1-cycle registered read, read suppressed on write cycles).
- Accepts residual/score update requests (address, signed delta) over a valid/ready handshake, reads the stored word, adds the delta with saturation and writes the result back.
- Also provides a clear sweep that zeroes every BRAM word before a new diffusion round.

Parameters:
- ADDR_WIDTH, 13, BRAM address width.
- DATA_WIDTH, 32, word width; stored values and deltas are two's-complement signed.
- DEPTH, 8192, number of BRAM words swept by clear; DEPTH <= 2^ADDR_WIDTH.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_clear_start  input  1  pulse; starts clear sweep (honoured only in IDLE).
- o_clear_busy  output  1  high while the sweep runs.
- i_upd_valid  input  1  update request valid.
- o_upd_ready  output  1  update request ready.
- i_upd_addr  input  ADDR_WIDTH  word to update.
- i_upd_delta  input  DATA_WIDTH  signed increment.
- o_upd_done  output  1  one-cycle pulse on the write-back cycle of an update.
- o_sat  output  1  one-cycle pulse with o_upd_done when the result saturated.
- o_bram_addr  output  ADDR_WIDTH  to BRAM i_addr.
- o_bram_write  output  1  to BRAM i_write.
- o_bram_data  output  DATA_WIDTH  to BRAM i_data.
- i_bram_data  input  DATA_WIDTH  from BRAM o_data.

Behaviour:
- Reset (async, any state, including mid-update or mid-clear):
  - State goes to IDLE; any in-flight update is dropped without a write.
  - o_bram_addr=0, o_bram_write=0, o_bram_data=0, o_clear_busy=0, o_upd_done=0, o_sat=0; internal clear counter=0.
- All BRAM-side outputs, o_clear_busy, o_upd_done and o_sat are registered.
- o_upd_ready = (state==IDLE) && !i_clear_start (combinational).
- FSM states: IDLE, RD, ADD, WR, CLR.
- IDLE:
  - i_clear_start=1: go to CLR, counter=0. Clear has priority over a simultaneous i_upd_valid, and that update is not accepted.
  - Else if i_upd_valid && o_upd_ready: latch addr/delta, set o_bram_addr=addr, o_bram_write=0, go to RD.
- RD: BRAM is addressed with write=0, so it captures the word at the end of this cycle. Go to ADD.
- ADD:
  - i_bram_data is valid. Compute sum = stored + delta at DATA_WIDTH+1 bits, signed.
  - If sum > 2^(DW-1)-1, clamp to the maximum and set the sat flag.
  - If sum < -2^(DW-1), clamp to the minimum and set the sat flag.
  - Register the result into o_bram_data, set o_bram_write=1, go to WR.
- WR:
  - BRAM writes this cycle; o_upd_done=1, and o_sat=flag.
  - On exit, o_bram_write returns to 0. Go to IDLE.
- Update latency: handshake cycle to write-back cycle is 3 cycles. Throughput is 1 update per 4 cycles; o_upd_ready is low in RD, ADD and WR.
- Back-to-back updates to the same address are correct with no forwarding needed, because each write completes before the next read.
- Handshake: i_upd_addr and i_upd_delta are sampled only on the handshake cycle and may change afterwards.
- CLR:
  - Each cycle: o_bram_addr=counter, o_bram_data=0, o_bram_write=1, o_clear_busy=1.
  - Counter increments per cycle; after address DEPTH-1 is written, return to IDLE with write=0 and busy=0.
  - A sweep takes exactly DEPTH write cycles.
  - i_clear_start during CLR is ignored (no restart). Updates are refused during CLR.
- No counter wrap issue: the counter is ADDR_WIDTH+1 bits wide and compares against DEPTH-1.
- Outputs hold their values in IDLE, except o_bram_write, o_upd_done and o_sat, which are 0.

Test Plan:
- Reset then clear with DEPTH=8192: o_clear_busy is high for exactly 8192 cycles, each address 0..8191 is written with 0, and o_upd_ready=0 throughout. Afterwards a read of addr 100 returns 0.
- After clear, updates (addr 5, +10) then (addr 5, -3): second write-back stores 7. Each o_upd_done comes 3 cycles after its handshake, and ready is low for 3 cycles after each acceptance.
- Word at addr 9 = 0x7FFFFFF0, update +0x20: stores 0x7FFFFFFF with o_sat=1. Word = 0x80000005, update -0x10: stores 0x80000000 with o_sat=1.
- i_clear_start and i_upd_valid asserted together in IDLE: o_upd_ready=0, the update is not accepted, and the clear sweep starts. The update is accepted once the sweep ends.
- Assert i_rst in the ADD state of an update to addr 42: no write to addr 42 occurs and all outputs are immediately 0. Also assert i_rst mid-clear at address 300: the sweep aborts and a new i_clear_start restarts from address 0.
- Burst of 4 consecutive updates to random addresses with valid held high: accepted every 4 cycles, and BRAM contents match a reference model.
